// File: rtl/core_pkg.sv
// Shared types for the NRC core memory arbiter: FSM state and transaction owner.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto one memory port, one outstanding transaction.
// Handshakes: a transfer happens on a cycle where valid && ready are both 1 at posedge clk.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit LSU_PRIO = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [XLEN-1:0]     ifu_req_addr,
  output logic                ifu_rsp_valid,
  output logic [XLEN-1:0]     ifu_rsp_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_req_write,
  input  logic [XLEN-1:0]     lsu_req_addr,
  input  logic [XLEN-1:0]     lsu_req_wdata,
  input  logic [XLEN/8-1:0]   lsu_req_wstrb,
  output logic                lsu_rsp_valid,
  output logic [XLEN-1:0]     lsu_rsp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_write,
  output logic [XLEN-1:0]     mem_req_addr,
  output logic [XLEN-1:0]     mem_req_wdata,
  output logic [XLEN/8-1:0]   mem_req_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [XLEN-1:0]     mem_rsp_rdata,
  output arb_state_e          dbg_state
);

  localparam int STRB_W = XLEN / 8;

  arb_state_e           r_state;
  arb_owner_e           r_owner;
  arb_owner_e           r_last_grant;
  logic                 r_mem_req_valid;
  logic                 r_mem_req_write;
  logic [XLEN-1:0]      r_mem_req_addr;
  logic [XLEN-1:0]      r_mem_req_wdata;
  logic [STRB_W-1:0]    r_mem_req_wstrb;

  logic                 w_grant_ifu;
  logic                 w_grant_lsu;
  logic                 w_rsp_fire;

  // Ties go to whoever was not served last; LSU_PRIO only ever favours the
  // LSU after an IFU grant, which keeps the alternation starvation-free.
  always_comb begin
    w_grant_ifu = 1'b0;
    w_grant_lsu = 1'b0;
    if (r_state == IDLE) begin
      if (ifu_req_valid && lsu_req_valid) begin
        if (LSU_PRIO && (r_last_grant == OWNER_IFU)) begin
          w_grant_lsu = 1'b1;
        end else if (r_last_grant == OWNER_LSU) begin
          w_grant_ifu = 1'b1;
        end else begin
          w_grant_lsu = 1'b1;
        end
      end else begin
        w_grant_ifu = ifu_req_valid;
        w_grant_lsu = lsu_req_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_owner         <= OWNER_IFU;
      r_last_grant    <= OWNER_LSU;
      r_mem_req_valid <= 1'b0;
      r_mem_req_write <= 1'b0;
      r_mem_req_addr  <= '0;
      r_mem_req_wdata <= '0;
      r_mem_req_wstrb <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_ifu) begin
            r_owner         <= OWNER_IFU;
            r_last_grant    <= OWNER_IFU;
            r_mem_req_valid <= 1'b1;
            r_mem_req_write <= 1'b0;
            r_mem_req_addr  <= ifu_req_addr;
            r_mem_req_wdata <= '0;
            r_mem_req_wstrb <= '0;
            r_state         <= REQ;
          end else if (w_grant_lsu) begin
            r_owner         <= OWNER_LSU;
            r_last_grant    <= OWNER_LSU;
            r_mem_req_valid <= 1'b1;
            r_mem_req_write <= lsu_req_write;
            r_mem_req_addr  <= lsu_req_addr;
            r_mem_req_wdata <= lsu_req_wdata;
            r_mem_req_wstrb <= lsu_req_wstrb;
            r_state         <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_mem_req_valid <= 1'b0;
          r_state         <= IDLE;
        end
      endcase
    end
  end

  assign ifu_req_ready = w_grant_ifu;
  assign lsu_req_ready = w_grant_lsu;

  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_write = r_mem_req_write;
  assign mem_req_addr  = r_mem_req_addr;
  assign mem_req_wdata = r_mem_req_wdata;
  assign mem_req_wstrb = r_mem_req_wstrb;

  // Responses outside WAIT_RSP are stray and never reach a requester.
  assign w_rsp_fire    = (r_state == WAIT_RSP) && mem_rsp_valid;
  assign ifu_rsp_valid = w_rsp_fire && (r_owner == OWNER_IFU);
  assign lsu_rsp_valid = w_rsp_fire && (r_owner == OWNER_LSU);
  assign ifu_rsp_rdata = ifu_rsp_valid ? mem_rsp_rdata : '0;
  assign lsu_rsp_rdata = lsu_rsp_valid ? mem_rsp_rdata : '0;

  assign dbg_state = r_state;

  a_one_grant : assert property (@(posedge clk) disable iff (rst)
    !(ifu_req_ready && lsu_req_ready));

  a_req_stable : assert property (@(posedge clk) disable iff (rst)
    (mem_req_valid && !mem_req_ready) |=>
      (mem_req_valid && $stable(mem_req_addr) && $stable(mem_req_wdata) &&
       $stable(mem_req_wstrb) && $stable(mem_req_write)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;
  import core_pkg::*;

  localparam int XLEN = 32;
  localparam int SW   = XLEN / 8;
  localparam int W    = 1 + XLEN + XLEN + SW;
  localparam logic [31:0] IA = 32'h8000_0000;
  localparam logic [31:0] LA = 32'h0000_0100;
  localparam logic [31:0] LD = 32'hDEAD_BEEF;
  localparam logic [31:0] RD = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  logic ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [XLEN-1:0] ifu_req_addr, ifu_rsp_rdata;
  logic lsu_req_valid, lsu_req_ready, lsu_req_write, lsu_rsp_valid;
  logic [XLEN-1:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
  logic [SW-1:0] lsu_req_wstrb;
  logic mem_req_valid, mem_req_ready, mem_req_write, mem_rsp_valid;
  logic [XLEN-1:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
  logic [SW-1:0] mem_req_wstrb;
  arb_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.XLEN(XLEN), .LSU_PRIO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_rdata(ifu_rsp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_write(lsu_req_write),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    ifu_req_valid = 1'b0; ifu_req_addr = IA;
    lsu_req_valid = 1'b0; lsu_req_write = 1'b0; lsu_req_addr = LA;
    lsu_req_wdata = LD; lsu_req_wstrb = 4'hF;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed vector table
  typedef struct {
    logic iv, lv, lw, mrdy, mrsp;
    logic [31:0] rd;
    logic eir, elr, emv, eirs, elrs, emw;
    logic [31:0] ema;
  } vec_t;

  function automatic vec_t mk(input logic iv, lv, lw, mrdy, mrsp, input logic [31:0] rd,
                              input logic eir, elr, emv, eirs, elrs, emw,
                              input logic [31:0] ema);
    vec_t v;
    v.iv = iv; v.lv = lv; v.lw = lw; v.mrdy = mrdy; v.mrsp = mrsp; v.rd = rd;
    v.eir = eir; v.elr = elr; v.emv = emv; v.eirs = eirs; v.elrs = elrs; v.emw = emw;
    v.ema = ema;
    return v;
  endfunction

  task automatic run_table();
    vec_t vecs[$];
    //                 iv lv lw rdy rsp rd      eir elr emv eirs elrs emw ema
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,      0, 0, 1, 0, 0, 0, IA));
    vecs.push_back(mk(0, 0, 0, 0, 1, RD,     0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, RD,     0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,      0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, RD,     0, 0, 1, 0, 0, 1, LA));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0, 0, 1, 0, 0, 1, LA));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0, 0, 1, 0, 0, 1, LA));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,      0, 0, 1, 0, 0, 1, LA));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 32'h55, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,      0, 0, 1, 0, 0, 0, IA));
    vecs.push_back(mk(0, 0, 0, 0, 1, RD,     0, 0, 0, 1, 0, 0, 0));
    // Back-to-back IFU with a 1-cycle memory: accepts every third cycle
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0,      0, 0, 1, 0, 0, 0, IA));
    vecs.push_back(mk(1, 0, 0, 1, 1, RD,     0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0,      1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0,      0, 0, 1, 0, 0, 0, IA));
    vecs.push_back(mk(1, 0, 0, 1, 1, 32'h77, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,      0, 0, 1, 0, 0, 0, IA));
    vecs.push_back(mk(0, 0, 0, 1, 1, RD,     0, 0, 0, 1, 0, 0, 0));
    foreach (vecs[i]) begin
      @(negedge clk);
      ifu_req_valid = vecs[i].iv; lsu_req_valid = vecs[i].lv; lsu_req_write = vecs[i].lw;
      mem_req_ready = vecs[i].mrdy; mem_rsp_valid = vecs[i].mrsp; mem_rsp_rdata = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_ifu_ready", i), ifu_req_ready, vecs[i].eir);
      chk($sformatf("v%0d_lsu_ready", i), lsu_req_ready, vecs[i].elr);
      chk($sformatf("v%0d_mem_valid", i), mem_req_valid, vecs[i].emv);
      chk($sformatf("v%0d_ifu_rsp", i), ifu_rsp_valid, vecs[i].eirs);
      chk($sformatf("v%0d_lsu_rsp", i), lsu_rsp_valid, vecs[i].elrs);
      if (vecs[i].emv) begin
        chk($sformatf("v%0d_mem_write", i), mem_req_write, vecs[i].emw);
        chk($sformatf("v%0d_mem_addr", i), mem_req_addr, vecs[i].ema);
        if (vecs[i].emw) begin
          chk($sformatf("v%0d_mem_wdata", i), mem_req_wdata, LD);
          chk($sformatf("v%0d_mem_wstrb", i), mem_req_wstrb, 4'hF);
        end else begin
          chk($sformatf("v%0d_mem_wstrb", i), mem_req_wstrb, 4'h0);
        end
      end
      if (vecs[i].eirs) chk($sformatf("v%0d_ifu_rdata", i), ifu_rsp_rdata, vecs[i].rd);
    end
  endtask

  // Both requesters continuously; the IFU was served last, so the LSU goes first
  task automatic dual_test();
    arb_owner_e grants[$];
    arb_owner_e exp_order[6] = '{OWNER_LSU, OWNER_IFU, OWNER_LSU, OWNER_IFU, OWNER_LSU, OWNER_IFU};
    int n_irsp = 0;
    int n_lrsp = 0;
    logic want = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      ifu_req_valid = (grants.size() < 6);
      lsu_req_valid = (grants.size() < 6);
      lsu_req_write = 1'b0;
      mem_req_ready = 1'b1;
      mem_rsp_valid = want;
      mem_rsp_rdata = $urandom;
      #1;
      if (ifu_req_ready) grants.push_back(OWNER_IFU);
      if (lsu_req_ready) grants.push_back(OWNER_LSU);
      if (ifu_rsp_valid) n_irsp++;
      if (lsu_rsp_valid) n_lrsp++;
      want = mem_req_valid && mem_req_ready;
    end
    chk("dual_grant_count", grants.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < grants.size()) chk($sformatf("dual_grant%0d", i), grants[i], exp_order[i]);
    end
    chk("dual_ifu_rsp_count", n_irsp, 3);
    chk("dual_lsu_rsp_count", n_lrsp, 3);
    drive_idle();
  endtask

  // Reset during WAIT_RSP drops the pending response
  task automatic reset_test();
    @(negedge clk); drive_idle(); ifu_req_valid = 1'b1; #1;
    chk("rst_t_accept", ifu_req_ready, 1'b1);
    @(negedge clk); ifu_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
    chk("rst_t_mem_valid", mem_req_valid, 1'b1);
    @(negedge clk); mem_req_ready = 1'b0; #1;
    chk("rst_t_wait_state", dbg_state, WAIT_RSP);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hBAD0_BAD0; #1;
    chk("rst_t_mem_valid0", mem_req_valid, 1'b0);
    chk("rst_t_mem_addr0", mem_req_addr, 0);
    chk("rst_t_mem_write0", mem_req_write, 1'b0);
    chk("rst_t_mem_wdata0", mem_req_wdata, 0);
    chk("rst_t_mem_wstrb0", mem_req_wstrb, 0);
    chk("rst_t_ifu_rsp_dropped", ifu_rsp_valid, 1'b0);
    chk("rst_t_lsu_rsp0", lsu_rsp_valid, 1'b0);
    chk("rst_t_state_idle", dbg_state, IDLE);
    @(negedge clk); mem_rsp_valid = 1'b0; ifu_req_valid = 1'b1; ifu_req_addr = IA + 4; #1;
    chk("rst_t_next_accept", ifu_req_ready, 1'b1);
    @(negedge clk); ifu_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
    chk("rst_t_next_addr", mem_req_addr, IA + 4);
    @(negedge clk); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = RD; #1;
    chk("rst_t_next_rsp", ifu_rsp_valid, 1'b1);
    chk("rst_t_next_rdata", ifu_rsp_rdata, RD);
    @(negedge clk); drive_idle();
  endtask

  // Randomized run: transaction-level model with an expected request queue
  task automatic random_test(input int ncyc);
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    logic busy = 1'b0, pending = 1'b0, waiting = 1'b0, m_write = 1'b0;
    arb_owner_e m_owner = OWNER_IFU;
    arb_owner_e m_last  = OWNER_LSU;
    logic i_acc = 1'b1, l_acc = 1'b1;
    logic e_i, e_l, e_rsp;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (!ifu_req_valid || i_acc) begin
        ifu_req_valid = ($urandom_range(0, 3) != 0);
        ifu_req_addr  = $urandom;
      end
      if (!lsu_req_valid || l_acc) begin
        lsu_req_valid = ($urandom_range(0, 3) != 0);
        lsu_req_write = $urandom_range(0, 1);
        lsu_req_addr  = $urandom;
        lsu_req_wdata = $urandom;
        lsu_req_wstrb = $urandom_range(0, 15);
      end
      i_acc = 1'b0; l_acc = 1'b0;
      mem_req_ready = ($urandom_range(0, 2) != 0);
      mem_rsp_valid = waiting ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      mem_rsp_rdata = $urandom;
      #1;
      // Only one grant while idle; a tie goes to the requester not served last
      e_i = 1'b0; e_l = 1'b0;
      if (!busy) begin
        if (ifu_req_valid && lsu_req_valid) begin
          if (m_last == OWNER_IFU) e_l = 1'b1; else e_i = 1'b1;
        end else begin
          e_i = ifu_req_valid; e_l = lsu_req_valid;
        end
      end
      chk("rnd_ifu_ready", ifu_req_ready, e_i);
      chk("rnd_lsu_ready", lsu_req_ready, e_l);
      chk("rnd_mem_valid", mem_req_valid, pending);
      if (pending && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("rnd_mem_write", mem_req_write, e[W-1]);
        chk("rnd_mem_addr", mem_req_addr, e[W-2 -: XLEN]);
        chk("rnd_mem_wstrb", mem_req_wstrb, e[SW-1:0]);
        if (e[W-1]) chk("rnd_mem_wdata", mem_req_wdata, e[SW +: XLEN]);
      end
      e_rsp = waiting && mem_rsp_valid;
      chk("rnd_ifu_rsp", ifu_rsp_valid, e_rsp && (m_owner == OWNER_IFU));
      chk("rnd_lsu_rsp", lsu_rsp_valid, e_rsp && (m_owner == OWNER_LSU));
      if (e_rsp && m_owner == OWNER_IFU) chk("rnd_ifu_rdata", ifu_rsp_rdata, mem_rsp_rdata);
      if (e_rsp && m_owner == OWNER_LSU && !m_write) chk("rnd_lsu_rdata", lsu_rsp_rdata, mem_rsp_rdata);
      if (e_rsp) begin
        waiting = 1'b0; busy = 1'b0;
      end
      if (pending && mem_req_ready) begin
        pending = 1'b0; waiting = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (e_i) begin
        exp_q.push_back({1'b0, ifu_req_addr, {XLEN{1'b0}}, {SW{1'b0}}});
        busy = 1'b1; pending = 1'b1; m_owner = OWNER_IFU; m_last = OWNER_IFU; m_write = 1'b0;
        i_acc = 1'b1;
      end
      if (e_l) begin
        exp_q.push_back({lsu_req_write, lsu_req_addr, lsu_req_wdata, lsu_req_wstrb});
        busy = 1'b1; pending = 1'b1; m_owner = OWNER_LSU; m_last = OWNER_LSU; m_write = lsu_req_write;
        l_acc = 1'b1;
      end
    end
    @(negedge clk); drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_mem_valid", mem_req_valid, 1'b0);
    chk("reset_mem_addr", mem_req_addr, 0);
    chk("reset_mem_wdata", mem_req_wdata, 0);
    chk("reset_mem_wstrb", mem_req_wstrb, 0);
    chk("reset_mem_write", mem_req_write, 1'b0);
    chk("reset_ifu_ready", ifu_req_ready, 1'b0);
    chk("reset_lsu_ready", lsu_req_ready, 1'b0);
    chk("reset_ifu_rsp", ifu_rsp_valid, 1'b0);
    chk("reset_lsu_rsp", lsu_rsp_valid, 1'b0);
    chk("reset_state", dbg_state, IDLE);
    rst = 1'b0;

    run_table();
    dual_test();
    reset_test();
    do_reset();
    random_test(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
